// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator front-end sequencer,
// the calculator itself and any behavioural model of the pair.
// Sequencer state encoding, phase codes seen by the display and op codes.
package calc_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_WAIT_A = 3'd0,
        ST_WAIT_B = 3'd1,
        ST_EXEC   = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Phase codes driven to the display decoders.
    localparam logic [1:0] PH_WAIT_A = 2'd0;
    localparam logic [1:0] PH_WAIT_B = 2'd1;
    localparam logic [1:0] PH_RESULT = 2'd2;
    localparam logic [1:0] PH_ERROR  = 2'd3;

    // Op codes understood by the calculator (passed through untouched).
    localparam int unsigned CALC_OPW = 3;
    localparam logic [CALC_OPW-1:0] OP_ADD = 3'd0;
    localparam logic [CALC_OPW-1:0] OP_SUB = 3'd1;
    localparam logic [CALC_OPW-1:0] OP_AND = 3'd2;
    localparam logic [CALC_OPW-1:0] OP_OR  = 3'd3;
    localparam logic [CALC_OPW-1:0] OP_XOR = 3'd4;

endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: turns a raw active-low push-button into a one-cycle
// press pulse. Two-flop synchronizer, then either a plain falling-edge
// detector or, with CALC_DEBOUNCE_EN defined, a stable-level debouncer
// that accepts a level change only after DEBOUNCE_CYCLES agreeing samples.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    logic sync_1;
    logic sync_2;

    // Synchronize the asynchronous key into the clock domain.
    always_ff @(posedge clk) begin
        // NOTE: synchronizer flops reset to the released (high) level so
        // leaving reset never looks like a key press.
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic             level;

    // Accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // pulse once when the accepted level goes low.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            level <= 1'b1;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                count <= '0;
                level <= sync_2;
                pulse <= ~sync_2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
`else
    logic sync_3;

    // Registered falling-edge detect on the synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_3 <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            sync_3 <= sync_2;
            pulse  <= sync_3 & ~sync_2;
        end
    end
`endif

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry / execute / result controller in front of
// the 4-bit combinational calculator. ENTER loads A, then B and op, then
// runs one EXEC cycle capturing R into acc; further ENTERs chain on acc.
// Overflow parks in ERROR until CLEAR. CLEAR always wins, in every state.
// Optional key debounce is enabled by defining CALC_DEBOUNCE_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned W               = 4,
    parameter int unsigned OPW             = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           enter_n,
    input  logic           clear_n,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   operand,
    output logic [W-1:0]   calc_a,
    output logic [W-1:0]   calc_b,
    output logic [OPW-1:0] calc_op,
    input  logic [W-1:0]   calc_r,
    input  logic           calc_ovf,
    output logic [W-1:0]   acc,
    output logic           err,
    output logic [1:0]     phase,
    output logic           busy
);

    logic   enter_p;
    logic   clear_p;
    state_t state;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_key (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (enter_n),
        .pulse (enter_p)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_key (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (clear_n),
        .pulse (clear_p)
    );

    // Sequencer FSM with registered outputs; CLEAR behaves like reset.
    // During EXEC the phase reads WAIT_B: operands are in, result pending.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register sees pre-edge values, independent of statement order.
        if (reset || clear_p) begin
            state   <= ST_WAIT_A;
            calc_a  <= '0;
            calc_b  <= '0;
            calc_op <= '0;
            acc     <= '0;
            err     <= 1'b0;
            phase   <= PH_WAIT_A;
            busy    <= 1'b0;
        end else begin
            busy <= 1'b0;
            case (state)
                ST_WAIT_A: begin
                    if (enter_p) begin
                        calc_a <= operand;
                        state  <= ST_WAIT_B;
                        phase  <= PH_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (enter_p) begin
                        calc_b  <= operand;
                        calc_op <= op;
                        state   <= ST_EXEC;
                        busy    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    acc <= calc_r;
                    if (calc_ovf) begin
                        err   <= 1'b1;
                        state <= ST_ERROR;
                        phase <= PH_ERROR;
                    end else begin
                        state <= ST_RESULT;
                        phase <= PH_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (enter_p) begin
                        calc_a  <= acc;
                        calc_b  <= operand;
                        calc_op <= op;
                        state   <= ST_EXEC;
                        phase   <= PH_WAIT_B;
                        busy    <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    // Only CLEAR leaves ERROR; ENTER is ignored here.
                end
                default: begin
                    state <= ST_WAIT_A;
                    phase <= PH_WAIT_A;
                end
            endcase
        end
    end

endmodule
